hilo_unit: RTL and testbench

HI/LO register unit for the MIPS multiply/divide extension. It sits beside the EX stage and owns the HI and LO registers. It executes MULT/MULTU on an internal radix-2 shift-add multiplier. For DIV it initiates and sequences the external signed `divider` block through that block's start/done interface. It also serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while an operation is in flight.

---
 rtl/hilo_unit.sv | 179 +++++++++++++++++
 tb/tb_hilo_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register unit for the MIPS multiply/divide extension.
// Owns HI/LO and runs MULT/MULTU on an internal radix-2 shift-add multiplier.
// Sequences the external signed divider for DIV, and serves MFHI/MFLO/MTHI/MTLO.
// Optional build macro: HILO_DIV_ZERO_TRAP_EN.
//   When defined, DIV by zero is resolved locally and pulses div_zero.
//   When undefined, DIV by zero goes to the divider like any other DIV.
module hilo_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_done,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_remainder
`ifdef HILO_DIV_ZERO_TRAP_EN
   ,
   output logic        div_zero
`endif
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_MFHI  = 3'd4;
   localparam logic [2:0] OP_MFLO  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL   = 3'd1,
      S_MFIX  = 3'd2,
      S_DIVW  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] hi, lo;
   logic [63:0] mcand;     // multiplicand magnitude, zero-extended
   logic [31:0] mplier;    // multiplier magnitude
   logic [63:0] acc;
   logic [4:0]  count;
   logic        neg;       // product must be negated in MFIX

   logic        accept;
   logic        is_signed;
   logic [31:0] rs_mag, rt_mag;

   assign accept    = op_valid & ~busy & ~flush;
   assign stall     = op_valid & busy;
   assign is_signed = (op == OP_MULT);
   // MULT works on magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude
   assign rs_mag    = (is_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
   assign rt_mag    = (is_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

   // Register read port: only meaningful for an unstalled MFHI/MFLO
   always_comb begin
      rdata = 32'd0;
      if (op_valid && !busy) begin
         if (op == OP_MFHI)      rdata = hi;
         else if (op == OP_MFLO) rdata = lo;
      end
   end

   // Control FSM, multiplier datapath and HI/LO update
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         hi           <= 32'd0;
         lo           <= 32'd0;
         mcand        <= 64'd0;
         mplier       <= 32'd0;
         acc          <= 64'd0;
         count        <= 5'd0;
         neg          <= 1'b0;
         busy         <= 1'b0;
         div_start    <= 1'b0;
         div_dividend <= 32'd0;
         div_divisor  <= 32'd0;
`ifdef HILO_DIV_ZERO_TRAP_EN
         div_zero     <= 1'b0;
`endif
      end else begin
         div_start <= 1'b0;
`ifdef HILO_DIV_ZERO_TRAP_EN
         div_zero  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        mcand  <= {32'd0, rs_mag};
                        mplier <= rt_mag;
                        neg    <= is_signed & (rs_val[31] ^ rt_val[31]);
                        acc    <= 64'd0;
                        count  <= 5'd0;
                        busy   <= 1'b1;
                        state  <= S_MUL;
                     end
                     OP_DIV: begin
`ifdef HILO_DIV_ZERO_TRAP_EN
                        if (rt_val == 32'd0) begin
                           hi       <= rs_val;
                           lo       <= 32'hFFFF_FFFF;
                           div_zero <= 1'b1;
                        end else begin
`else
                        begin
`endif
                           // operands stay put until div_done: the divider reads them every cycle
                           div_dividend <= rs_val;
                           div_divisor  <= rt_val;
                           div_start    <= 1'b1;
                           busy         <= 1'b1;
                           state        <= S_DIVW;
                        end
                     end
                     OP_MTHI: hi <= rs_val;
                     OP_MTLO: lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               if (flush) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  if (mplier[count])
                     acc <= acc + (mcand << count);
                  count <= count + 5'd1;
                  if (count == 5'd31)
                     state <= S_MFIX;
               end
            end
            S_MFIX: begin
               if (!flush)
                  {hi, lo} <= neg ? (~acc + 64'd1) : acc;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_DIVW: begin
               if (div_done) begin
                  // a flush landing on the done cycle discards the result; nothing left to drain
                  if (!flush) begin
                     lo <= div_quotient;
                     hi <= div_remainder;
                  end
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (flush) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (div_done) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a behavioural signed divider attached.
// Reference model: HI/LO computed directly from MULT/MULTU/DIV/MT* arithmetic.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
   logic        flush = 1'b0;
   logic        stall, busy, div_start;
   logic [31:0] rdata, div_dividend, div_divisor;
   logic        div_done = 1'b0;
   logic [31:0] div_quotient = 32'd0, div_remainder = 32'd0;
`ifdef HILO_DIV_ZERO_TRAP_EN
   logic        div_zero;
`endif

   int compared = 0, mismatched = 0;
   int start_cnt = 0;
   int lat = 0;
   logic pend = 1'b0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

   hilo_unit dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
      .stall(stall), .rdata(rdata), .busy(busy),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
`ifdef HILO_DIV_ZERO_TRAP_EN
      , .div_zero(div_zero)
`endif
   );

   always #5 clk = ~clk;

   // {remainder, quotient} of signed division; divide-by-zero gives {dividend, all ones}
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = int'(a); sb = int'(b);
      q = sa / sb; r = sa % sb;
      return {32'(r), 32'(q)};
   endfunction

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint pa, pb;
      if (sgn) begin pa = longint'(int'(a)); pb = longint'(int'(b)); end
      else begin pa = longint'({32'd0, a}); pb = longint'({32'd0, b}); end
      return 64'(pa * pb);
   endfunction

   // Behavioural divider: random latency, reads operands at completion (so unstable operands show up)
   always @(posedge clk) begin
      div_done <= 1'b0;
      if (rst) begin
         pend <= 1'b0;
      end else if (div_start) begin
         pend      <= 1'b1;
         lat       <= $urandom_range(3, 12);
         start_cnt <= start_cnt + 1;
      end else if (pend) begin
         if (lat == 0) begin
            pend     <= 1'b0;
            div_done <= 1'b1;
            {div_remainder, div_quotient} <= ref_div(div_dividend, div_divisor);
         end else begin
            lat <= lat - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Present an op, hold it while stalled, let it be accepted, update the model
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic [31:0] rd);
      @(negedge clk);
      op_valid = 1'b1; op = o; rs_val = a; rt_val = b; stalls = 0;
      #1;
      while (stall === 1'b1 && stalls < 300) begin
         stalls++;
         @(negedge clk); #1;
      end
      if (stalls >= 300) chk("stall_timeout", {63'd0, stall}, 64'd0);
      rd = rdata;
      @(posedge clk); #1;
      op_valid = 1'b0; op = 3'd0;
      case (o)
         3'd1: {m_hi, m_lo} = ref_mul(a, b, 1'b1);
         3'd2: {m_hi, m_lo} = ref_mul(a, b, 1'b0);
         3'd3: {m_hi, m_lo} = ref_div(a, b);
         3'd6: m_hi = a;
         3'd7: m_lo = a;
         default: ;
      endcase
   endtask

   // Read HI then LO against the model; returns stall cycles of the first read
   task automatic read_hl(input string tag, output int st0);
      int st1;
      logic [31:0] rd;
      issue(3'd4, 32'd0, 32'd0, st0, rd);
      chk({tag, "_hi"}, {32'd0, rd}, {32'd0, m_hi});
      issue(3'd5, 32'd0, 32'd0, st1, rd);
      chk({tag, "_lo"}, {32'd0, rd}, {32'd0, m_lo});
      chk({tag, "_lo_nostall"}, 64'(st1), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int st, s0, n;
      logic [31:0] rd, a, b, sh, sl;
      logic [2:0] o;
      logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_div_start", {63'd0, div_start}, 64'd0);
      chk("rst_dividend", {32'd0, div_dividend}, 64'd0);
      chk("rst_divisor", {32'd0, div_divisor}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      chk("rst_rdata", {32'd0, rdata}, 64'd0);
      rst = 1'b0;
      read_hl("reset_regs", st);

      // MULT -3 * 5, immediate MFLO stalls 33 cycles
      issue(3'd1, 32'hFFFF_FFFD, 32'd5, st, rd);
      chk("mult_busy", {63'd0, busy}, 64'd1);
      issue(3'd5, 32'd0, 32'd0, st, rd);
      chk("mult_stalls", 64'(st), 64'd33);
      chk("mult_lo", {32'd0, rd}, 64'h0000_0000_FFFF_FFF1);
      issue(3'd4, 32'd0, 32'd0, st, rd);
      chk("mult_hi", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);

      // MULTU max * max
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, rd);
      issue(3'd5, 32'd0, 32'd0, st, rd);
      chk("multu_stalls", 64'(st), 64'd33);
      chk("multu_lo", {32'd0, rd}, 64'd1);
      issue(3'd4, 32'd0, 32'd0, st, rd);
      chk("multu_hi", {32'd0, rd}, 64'h0000_0000_FFFF_FFFE);

      // DIV 100/7 and -100/7
      s0 = start_cnt;
      issue(3'd3, 32'd100, 32'd7, st, rd);
      chk("div_start_pulse", {63'd0, div_start}, 64'd1);
      @(posedge clk); #1;
      chk("div_start_drop", {63'd0, div_start}, 64'd0);
      read_hl("div_100_7", st);
      chk("div_lo_14", {32'd0, m_lo}, 64'd14);
      chk("div_start_count", 64'(start_cnt - s0), 64'd1);
      issue(3'd3, 32'hFFFF_FF9C, 32'd7, st, rd);
      read_hl("div_m100_7", st);

      // MTHI / MTLO then reads, no stall
      issue(3'd6, 32'h1234_5678, 32'd0, st, rd);
      issue(3'd7, 32'h9ABC_DEF0, 32'd0, st, rd);
      read_hl("mt", st);
      chk("mt_nostall", 64'(st), 64'd0);

      // flush together with op_valid in IDLE: not accepted
      @(negedge clk);
      op_valid = 1'b1; op = 3'd6; rs_val = 32'hDEAD_BEEF; flush = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      read_hl("flush_idle", st);

      // flush mid-multiply
      sh = m_hi; sl = m_lo;
      issue(3'd2, $urandom, $urandom, st, rd);
      repeat (10) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk("flush_mul_busy", {63'd0, busy}, 64'd0);
      m_hi = sh; m_lo = sl;
      read_hl("flush_mul", st);

      // flush mid-divide: busy held until div_done, result dropped
      sh = m_hi; sl = m_lo; s0 = start_cnt;
      issue(3'd3, 32'd1000, 32'd3, st, rd);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk("flush_div_busy", {63'd0, busy}, 64'd1);
      n = 0;
      while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("flush_div_drain_done", {63'd0, busy}, 64'd0);
      chk("flush_div_starts", 64'(start_cnt - s0), 64'd1);
      m_hi = sh; m_lo = sl;
      read_hl("flush_div", st);

      // divide by zero
      s0 = start_cnt;
      issue(3'd3, 32'd42, 32'd0, st, rd);
`ifdef HILO_DIV_ZERO_TRAP_EN
      chk("dz_no_start", {63'd0, div_start}, 64'd0);
      chk("dz_pulse", {63'd0, div_zero}, 64'd1);
      chk("dz_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      chk("dz_pulse_drop", {63'd0, div_zero}, 64'd0);
      chk("dz_starts", 64'(start_cnt - s0), 64'd0);
`else
      chk("dz_forward_start", {63'd0, div_start}, 64'd1);
`endif
      read_hl("div_zero", st);

      // randomized ops against the model
      for (int i = 0; i < 24; i++) begin
         o = ops[$urandom_range(0, 4)];
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd1;
            1: b = 32'd4;
            2: b = 32'd8;
            3: b = a;
            4: b = 32'hFFFF_FFF9;
            default: b = $urandom;
         endcase
         issue(o, a, b, st, rd);
         read_hl($sformatf("rand%0d_op%0d", i, o), st);
         if (o == 3'd1 || o == 3'd2) chk($sformatf("rand%0d_stalls", i), 64'(st), 64'd33);
      end

      // reset mid-multiply
      issue(3'd1, $urandom, $urandom, st, rd);
      repeat (5) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("rst_mul_busy", {63'd0, busy}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      read_hl("rst_mul", st);

      // reset while div_start is high
      s0 = start_cnt;
      issue(3'd3, 32'd77, 32'd5, st, rd);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("rst_div_start", {63'd0, div_start}, 64'd0);
      chk("rst_div_busy", {63'd0, busy}, 64'd0);
      chk("rst_div_starts", 64'(start_cnt - s0), 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      read_hl("rst_div", st);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
